rf_sb: RTL and testbench
========================

RF_SB -- requirements
Module: rf_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter ADR_W, default 5, address width; depth = 2**ADR_W entries.
REQ-003 Parameter NB_RD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1; when 1, entry 0 reads as zero, ignores writes and is never busy.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rd_adr_i  input  NB_RD*ADR_W  read addresses; port k uses slice [k*ADR_W +: ADR_W].
REQ-008 rd_data_o  output  NB_RD*XLEN  read data; port k uses slice [k*XLEN +: XLEN].
REQ-009 rd_busy_o  output  NB_RD  port k addressed entry has an outstanding producer.
REQ-010 wr0_valid_i / wr1_valid_i  input  1  write port enables.
REQ-011 wr0_adr_i / wr1_adr_i  input  ADR_W  write addresses.
REQ-012 wr0_data_i / wr1_data_i  input  XLEN  write data.
REQ-013 alloc_valid_i  input  1  request to mark alloc_adr_i busy (instruction issue).
REQ-014 alloc_adr_i  input  ADR_W  destination being allocated.
REQ-015 alloc_ready_o  output  1  allocation accepted this cycle.
REQ-016 flush_i  input  1  clear all busy bits.
REQ-017 busy_cnt_o  output  ADR_W+1  number of busy entries, registered.

Function
REQ-018 Write: on clk edge, wrN_valid_i writes wrN_data_i to wrN_adr_i; writes to entry 0 are dropped when ZERO_REG=1.
REQ-019 Write collision: both ports valid, same address -> wr1 data stored.
REQ-020 Read: combinational, zero cycle latency from rd_adr_i.
REQ-021 Bypass: a valid write this cycle to the read address is forwarded to rd_data_o; wr1 takes precedence over wr0.
REQ-022 Entry 0 with ZERO_REG=1: rd_data_o = 0, rd_busy_o = 0, regardless of bypass or state.
REQ-023 Busy clear: a valid write to an entry clears its busy bit at the clock edge.
REQ-024 alloc_ready_o = ~busy[alloc_adr_i] | (valid write to alloc_adr_i this cycle) | (ZERO_REG=1 and alloc_adr_i=0); combinational, independent of alloc_valid_i.
REQ-025 Busy set: alloc_valid_i & alloc_ready_o sets busy[alloc_adr_i]; with a same-cycle write to the same entry, set wins (busy stays 1).
REQ-026 Allocation to entry 0 with ZERO_REG=1 is accepted with no state change.
REQ-027 rd_busy_o[k] = busy[rd_adr_k] & ~(valid write to rd_adr_k this cycle).
REQ-028 Flush: flush_i clears every busy bit at the clock edge; overrides any same-cycle allocation; same-cycle writes still update data.
REQ-029 busy_cnt_o tracks the population of busy bits after each edge: +1 on set, -1 on clear, net 0 when both hit different entries' net; 0 after flush; never exceeds 2**ADR_W (or 2**ADR_W-1 with ZERO_REG=1).
REQ-030 Writes to non-busy entries are legal and do not change busy_cnt_o.

Reset
REQ-031 reset asserted: all data entries, busy bits and busy_cnt_o become 0 immediately, independent of clk.
REQ-032 After reset deassertion, alloc_ready_o = 1 for every address and all rd_busy_o = 0.
REQ-033 reset mid-operation discards outstanding allocations and pending writes of that cycle.

Verification
REQ-034 Write wr0 adr 5 data 0xDEADBEEF; next cycle read port 0 adr 5 -> 0xDEADBEEF; same cycle as write -> bypassed 0xDEADBEEF.
REQ-035 wr0 adr 7 data 0x1, wr1 adr 7 data 0x2 same cycle -> read adr 7 returns 0x2 (both bypass and stored).
REQ-036 Write adr 0 data 0xFFFFFFFF, alloc adr 0 (ZERO_REG=1) -> read adr 0 = 0, rd_busy_o = 0, busy_cnt_o = 0.
REQ-037 Alloc adr 3 -> rd_busy_o=1, busy_cnt_o=1, alloc adr 3 again -> alloc_ready_o=0; write adr 3 with alloc adr 3 same cycle -> ready=1, busy stays 1, count 1.
REQ-038 Alloc adr 1,2,4 over 3 cycles -> busy_cnt_o=3; flush_i with alloc adr 6 -> all busy 0, busy_cnt_o=0.
REQ-039 Write several entries, assert reset between clock edges -> all reads 0, busy_cnt_o=0 without a clock edge.

Source files
------------

// File: rtl/rf_sb.sv
// rf_sb: register file with a per-entry scoreboard of outstanding producers.
// Two write ports with same-cycle bypass, NB_RD combinational read ports, and
// busy-bit tracking for instruction issue (alloc), writeback (clear) and flush.
//
// Allocation handshake: alloc_valid_i requests marking alloc_adr_i busy;
// alloc_ready_o is a pure function of current state and this cycle's writes
// (never of alloc_valid_i), and the allocation takes effect at the clock edge
// only in cycles where alloc_valid_i and alloc_ready_o are both high.
module rf_sb #(
   parameter int XLEN     = 32,
   parameter int ADR_W    = 5,
   parameter int NB_RD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NB_RD*ADR_W-1:0] rd_adr_i,
   output logic [NB_RD*XLEN-1:0]  rd_data_o,
   output logic [NB_RD-1:0]       rd_busy_o,
   input  logic                   wr0_valid_i,
   input  logic [ADR_W-1:0]       wr0_adr_i,
   input  logic [XLEN-1:0]        wr0_data_i,
   input  logic                   wr1_valid_i,
   input  logic [ADR_W-1:0]       wr1_adr_i,
   input  logic [XLEN-1:0]        wr1_data_i,
   input  logic                   alloc_valid_i,
   input  logic [ADR_W-1:0]       alloc_adr_i,
   output logic                   alloc_ready_o,
   input  logic                   flush_i,
   output logic [ADR_W:0]         busy_cnt_o
);

   localparam int DEPTH   = 2**ADR_W;
   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [XLEN-1:0]  mem_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [ADR_W:0]   busy_cnt_q, busy_cnt_d;

   logic wr0_eff, wr1_eff, alloc_take;

   // True for the hard-wired zero entry when that feature is enabled.
   function automatic logic is_zero(input logic [ADR_W-1:0] a);
      return ZERO_EN && (a == '0);
   endfunction

   // Writes that actually land; writes aimed at the zero entry are dropped.
   assign wr0_eff = wr0_valid_i && !is_zero(wr0_adr_i);
   assign wr1_eff = wr1_valid_i && !is_zero(wr1_adr_i);

   // Allocation is possible when the entry is free, is being written back this
   // cycle, or is the zero entry (accepted but has no effect).
   always_comb begin
      alloc_ready_o = !busy_q[alloc_adr_i]
                    || (wr0_valid_i && (wr0_adr_i == alloc_adr_i))
                    || (wr1_valid_i && (wr1_adr_i == alloc_adr_i))
                    || is_zero(alloc_adr_i);
      alloc_take    = alloc_valid_i && alloc_ready_o && !is_zero(alloc_adr_i);
   end

   // Next data/busy state and the population count of the new busy vector.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      // wr1 applied last so it wins an address collision.
      if (wr0_eff) begin
         mem_d[wr0_adr_i]  = wr0_data_i;
         busy_d[wr0_adr_i] = 1'b0;
      end
      if (wr1_eff) begin
         mem_d[wr1_adr_i]  = wr1_data_i;
         busy_d[wr1_adr_i] = 1'b0;
      end
      // Set after clear: a same-cycle writeback and reissue leaves it busy.
      if (alloc_take) begin
         busy_d[alloc_adr_i] = 1'b1;
      end
      if (flush_i) begin
         busy_d = '0;
      end
      if (ZERO_EN) begin
         busy_d[0] = 1'b0;
      end
      busy_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_cnt_d = busy_cnt_d + {{ADR_W{1'b0}}, busy_d[i]};
      end
   end

   // State registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt_o = busy_cnt_q;

   // Per-port read: stored value, overridden by wr0 then wr1 bypass, zero entry forced.
   for (genvar k = 0; k < NB_RD; k++) begin : g_rd
      logic [ADR_W-1:0] ra;
      logic [XLEN-1:0]  rdata;
      logic             rbusy;
      logic             hit0, hit1;

      assign ra   = rd_adr_i[k*ADR_W +: ADR_W];
      assign hit0 = wr0_valid_i && (wr0_adr_i == ra);
      assign hit1 = wr1_valid_i && (wr1_adr_i == ra);

      // Read data and busy for this port.
      always_comb begin
         rdata = mem_q[ra];
         rbusy = busy_q[ra] && !hit0 && !hit1;
         if (hit0) begin
            rdata = wr0_data_i;
         end
         if (hit1) begin
            rdata = wr1_data_i;
         end
         if (is_zero(ra)) begin
            rdata = '0;
            rbusy = 1'b0;
         end
      end

      assign rd_data_o[k*XLEN +: XLEN] = rdata;
      assign rd_busy_o[k]              = rbusy;
   end

endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: directed vectors with literal expectations, a short randomised
// phase, and a per-cycle comparison against a behavioural register-file model.
module tb_rf_sb;

  localparam int XLEN  = 32;
  localparam int ADR_W = 5;
  localparam int NB_RD = 2;
  localparam int DEPTH = 2**ADR_W;

  logic                   clk;
  logic                   reset;
  logic [NB_RD*ADR_W-1:0] rd_adr_i;
  logic [NB_RD*XLEN-1:0]  rd_data_o;
  logic [NB_RD-1:0]       rd_busy_o;
  logic                   wr0_valid_i, wr1_valid_i;
  logic [ADR_W-1:0]       wr0_adr_i, wr1_adr_i;
  logic [XLEN-1:0]        wr0_data_i, wr1_data_i;
  logic                   alloc_valid_i;
  logic [ADR_W-1:0]       alloc_adr_i;
  logic                   alloc_ready_o;
  logic                   flush_i;
  logic [ADR_W:0]         busy_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  logic [XLEN-1:0] exp_q[$];

  // Model state: entry contents and set of outstanding producers.
  logic [XLEN-1:0] m_mem  [DEPTH];
  bit              m_busy [DEPTH];

  rf_sb #(.XLEN(XLEN), .ADR_W(ADR_W), .NB_RD(NB_RD), .ZERO_REG(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_adr_i      (rd_adr_i),
    .rd_data_o     (rd_data_o),
    .rd_busy_o     (rd_busy_o),
    .wr0_valid_i   (wr0_valid_i),
    .wr0_adr_i     (wr0_adr_i),
    .wr0_data_i    (wr0_data_i),
    .wr1_valid_i   (wr1_valid_i),
    .wr1_adr_i     (wr1_adr_i),
    .wr1_data_i    (wr1_data_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_adr_i   (alloc_adr_i),
    .alloc_ready_o (alloc_ready_o),
    .flush_i       (flush_i),
    .busy_cnt_o    (busy_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic bit written(input int a);
    return (wr0_valid_i && int'(wr0_adr_i) == a) || (wr1_valid_i && int'(wr1_adr_i) == a);
  endfunction

  function automatic logic [XLEN-1:0] model_rd(input int a);
    if (a == 0) return '0;
    if (wr1_valid_i && int'(wr1_adr_i) == a) return wr1_data_i;
    if (wr0_valid_i && int'(wr0_adr_i) == a) return wr0_data_i;
    return m_mem[a];
  endfunction

  function automatic bit model_rbusy(input int a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !written(a);
  endfunction

  function automatic bit model_ready(input int a);
    return (a == 0) || !m_busy[a] || written(a);
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit model_next_busy(input int a);
    if (a == 0 || flush_i) return 1'b0;
    if (alloc_valid_i && int'(alloc_adr_i) == a && model_ready(a)) return 1'b1;
    if (written(a)) return 1'b0;
    return m_busy[a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] <= model_next_busy(i);
      if (wr0_valid_i && wr0_adr_i != '0) m_mem[wr0_adr_i] <= wr0_data_i;
      if (wr1_valid_i && wr1_adr_i != '0) m_mem[wr1_adr_i] <= wr1_data_i;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] rd_data(input int k);
    return rd_data_o[k*XLEN +: XLEN];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NB_RD; k++) begin
        int a;
        a = int'(rd_adr_i[k*ADR_W +: ADR_W]);
        exp_q.push_back(model_rd(a));
        check("cyc_rd_data", rd_data(k), exp_q.pop_front());
        check("cyc_rd_busy", rd_busy_o[k], model_rbusy(a));
      end
      check("cyc_ready", alloc_ready_o, model_ready(int'(alloc_adr_i)));
      check("cyc_cnt", busy_cnt_o, model_cnt());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr0_valid_i = 0; wr0_adr_i = '0; wr0_data_i = '0;
    wr1_valid_i = 0; wr1_adr_i = '0; wr1_data_i = '0;
    alloc_valid_i = 0; alloc_adr_i = '0; flush_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_adr_i[0*ADR_W +: ADR_W] = ADR_W'(a0);
    rd_adr_i[1*ADR_W +: ADR_W] = ADR_W'(a1);
  endtask

  task automatic wr0(input int a, input logic [XLEN-1:0] d);
    wr0_valid_i = 1; wr0_adr_i = ADR_W'(a); wr0_data_i = d;
  endtask

  task automatic wr1(input int a, input logic [XLEN-1:0] d);
    wr1_valid_i = 1; wr1_adr_i = ADR_W'(a); wr1_data_i = d;
  endtask

  task automatic alloc(input int a);
    alloc_valid_i = 1; alloc_adr_i = ADR_W'(a);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle();
    set_rd(0, 0);
    #3;
    check("rst_cnt", busy_cnt_o, 0);
    check("rst_ready", alloc_ready_o, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1;

    // Write then read, with same-cycle bypass.
    step(); idle(); wr0(5, 32'hDEADBEEF); set_rd(5, 1);
    #1 check("byp_5", rd_data(0), 32'hDEADBEEF);
    step(); idle(); set_rd(5, 1);
    #1 check("stored_5", rd_data(0), 32'hDEADBEEF);

    // Write collision: wr1 wins in bypass and in storage.
    step(); idle(); wr0(7, 32'h1); wr1(7, 32'h2); set_rd(7, 7);
    #1 check("byp_7_p0", rd_data(0), 32'h2);
    check("byp_7_p1", rd_data(1), 32'h2);
    step(); idle(); set_rd(7, 5);
    #1 check("stored_7", rd_data(0), 32'h2);

    // Zero entry ignores writes and allocation.
    step(); idle(); wr0(0, 32'hFFFFFFFF); alloc(0); set_rd(0, 7);
    #1 check("zero_rd", rd_data(0), 0);
    check("zero_busy", rd_busy_o[0], 0);
    check("zero_ready", alloc_ready_o, 1);
    step(); idle(); set_rd(0, 7);
    #1 check("zero_cnt", busy_cnt_o, 0);
    check("zero_rd_after", rd_data(0), 0);

    // Allocate 3, reject re-allocation, then writeback + reissue same cycle.
    step(); idle(); alloc(3); set_rd(3, 0);
    #1 check("a3_ready", alloc_ready_o, 1);
    step(); idle(); set_rd(3, 0);
    #1 check("a3_busy", rd_busy_o[0], 1);
    check("a3_cnt", busy_cnt_o, 1);
    alloc(3);
    #1 check("a3_again_ready", alloc_ready_o, 0);
    step(); idle(); alloc(3); wr0(3, 32'hAA); set_rd(3, 0);
    #1 check("a3_wb_ready", alloc_ready_o, 1);
    check("a3_wb_rbusy", rd_busy_o[0], 0);
    check("a3_wb_cnt", busy_cnt_o, 1);
    step(); idle(); set_rd(3, 0);
    #1 check("a3_set_wins", rd_busy_o[0], 1);
    check("a3_set_cnt", busy_cnt_o, 1);
    check("a3_data", rd_data(0), 32'hAA);

    // Allocate 1 while clearing 3 (net 0), then 2 and 4; flush with alloc 6.
    step(); idle(); alloc(1); wr1(3, 32'h33);
    step(); idle(); alloc(2);
    #1 check("net0_cnt", busy_cnt_o, 1);
    step(); idle(); alloc(4);
    step(); idle(); set_rd(4, 2);
    #1 check("three_cnt", busy_cnt_o, 3);
    step(); idle(); flush_i = 1; alloc(6);
    #1 check("flush_ready", alloc_ready_o, 1);
    step(); idle(); set_rd(6, 1);
    #1 check("flush_cnt", busy_cnt_o, 0);
    check("flush_b6", rd_busy_o[0], 0);
    check("flush_b1", rd_busy_o[1], 0);

    // Randomised traffic over a small address window, checked by the model.
    for (int i = 0; i < 300; i++) begin
      step(); idle();
      if ($urandom_range(0, 2) == 0) wr0($urandom_range(0, 7), $urandom());
      if ($urandom_range(0, 2) == 0) wr1($urandom_range(0, 7), $urandom());
      if ($urandom_range(0, 1) == 0) alloc($urandom_range(0, 7));
      flush_i = ($urandom_range(0, 24) == 0);
      set_rd($urandom_range(0, 7), $urandom_range(0, 7));
    end

    // Asynchronous reset between edges clears data and count.
    step(); idle(); wr0(9, 32'h12345678); alloc(10); set_rd(9, 10);
    step(); idle(); set_rd(9, 10);
    #1 check("pre_rst_9", rd_data(0), 32'h12345678);
    check("pre_rst_b10", rd_busy_o[1], 1);
    wr1(11, 32'h5A5A5A5A); alloc(12);
    #1 reset = 1'b1;
    #1 check("async_rd9", rd_data(0), 0);
    check("async_cnt", busy_cnt_o, 0);
    check("async_b10", rd_busy_o[1], 0);
    idle();
    step(); step();
    reset = 1'b0;
    chk_en = 0;
    for (int a = 0; a < DEPTH; a++) begin
      alloc_adr_i = ADR_W'(a);
      set_rd(a, 11);
      #0.1;
      check("post_rst_ready", alloc_ready_o, 1);
      check("post_rst_rbusy", rd_busy_o[0], 0);
      check("post_rst_rd", rd_data(1), 0);
    end
    step(); idle();
    chk_en = 1;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
